// File: rtl/mult_acc_4bits.sv
// Sequential multiply-accumulate: sums LEN unsigned A*B products (optional MULT_ACC_SAT_EN saturates Acc).
// Latency: operand accept to Acc update 2 cycles, one pair per 3 cycles; result valid after LEN pairs.
// Backpressure: in_ready only while collecting; result held in DONE until out_ready.
module mult_acc_4bits #(
  parameter int bits     = 4,
  parameter int acc_bits = 12,
  parameter int LEN      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bits-1:0]     A,
  input  logic [bits-1:0]     B,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [acc_bits-1:0] Acc,
  output logic                Overflow
);

  localparam int CNT_W = $clog2(LEN + 1);

  typedef enum logic [1:0] {COLLECT, MULT, ADD, DONE} state_t;

  state_t                state, state_nxt;
  logic [bits-1:0]       A_r, B_r;
  logic [2*bits-1:0]     product, prod_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [acc_bits:0]     sum;
  logic [acc_bits-1:0]   acc_nxt;
  logic                  last_pair;

  // Shift/add multiplier evaluated from the registered operands.
  always_comb begin
    prod_nxt = '0;
    for (int i = 0; i < bits; i++) begin
      if (B_r[i]) begin
        prod_nxt = prod_nxt + ({{bits{1'b0}}, A_r} << i);
      end
    end
  end

  assign sum       = {1'b0, Acc} + {{(acc_bits + 1 - 2*bits){1'b0}}, product};
  assign last_pair = (cnt == CNT_W'(LEN - 1));

`ifdef MULT_ACC_SAT_EN
  assign acc_nxt = sum[acc_bits] ? {acc_bits{1'b1}} : sum[acc_bits-1:0];
`else
  assign acc_nxt = sum[acc_bits-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MULT;
      end
      MULT:    state_nxt = ADD;
      ADD:     state_nxt = last_pair ? DONE : COLLECT;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // cnt returns to 0 on the final add so it never reaches LEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      A_r      <= '0;
      B_r      <= '0;
      product  <= '0;
      Acc      <= '0;
      cnt      <= '0;
      Overflow <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (in_valid) begin
            A_r <= A;
            B_r <= B;
          end
        end
        MULT: product <= prod_nxt;
        ADD: begin
          Acc      <= acc_nxt;
          Overflow <= Overflow | sum[acc_bits];
          cnt      <= last_pair ? '0 : cnt + CNT_W'(1);
        end
        DONE: begin
          if (out_ready) begin
            Acc      <= '0;
            cnt      <= '0;
            Overflow <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
